// File: rtl/coherence_bus_ctrl.sv
// Dual-core MSI snooping bus controller over a single-port RAM.
// Optional perf counters: define BUS_PERF_CNT_EN.
module coherence_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
`ifdef BUS_PERF_CNT_EN
  ,
  output logic [31:0]            c2c_count,
  output logic [31:0]            ram_access_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, IFETCH, DWB, SNOOP, C2C, DRAM_RD
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              req_q, req_d;
  logic              held_q, held_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              oth;
  logic              acc;
  logic              done;
  logic [CPUS-1:0]   wb_v, sn_v;

  assign oth  = ~req_q;
  assign acc  = (ramstate == RAM_ACCESS);
  assign wb_v = dWEN & ~cctrans;
  assign sn_v = cctrans & (dREN | dWEN);

  function automatic logic [WORD_W-1:0] wsel(
    input logic [CPUS*WORD_W-1:0] v,
    input logic                   i
  );
    return i ? v[2*WORD_W-1:WORD_W] : v[WORD_W-1:0];
  endfunction

  function automatic logic [CPUS*WORD_W-1:0] wput(
    input logic [WORD_W-1:0] w,
    input logic              i
  );
    return i ? {w, {WORD_W{1'b0}}} : {{WORD_W{1'b0}}, w};
  endfunction

  // rr pointer wins a tie inside one request class
  function automatic logic pick(
    input logic [CPUS-1:0] v,
    input logic            rr
  );
    return v[rr] ? rr : ~rr;
  endfunction

  // next-state, grant latch and all bus/cache outputs
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    req_d       = req_q;
    addr_d      = addr_q;
    held_d      = 1'b0;
    done        = 1'b0;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state_q)
      IDLE: begin
        priority case (1'b1)
          |wb_v: begin
            state_d = DWB;
            req_d   = pick(wb_v, rr_q);
            addr_d  = wsel(daddr, req_d);
          end
          |sn_v: begin
            state_d = SNOOP;
            req_d   = pick(sn_v, rr_q);
            addr_d  = wsel(daddr, req_d);
          end
          |iREN: begin
            state_d = IFETCH;
            req_d   = pick(iREN, rr_q);
            addr_d  = wsel(iaddr, req_d);
          end
          default: ;
        endcase
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (acc) begin
          iwait[req_q] = 1'b0;
          iload        = wput(ramload, req_q);
          done         = 1'b1;
        end
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = wsel(dstore, req_q);
        if (acc) begin
          dwait[req_q] = 1'b0;
          done         = 1'b1;
        end
      end
      SNOOP: begin
        ccwait[oth] = 1'b1;
        ccinv[oth]  = ccwrite[req_q];
        ccsnoopaddr = wput(addr_q, oth);
        held_d      = 1'b1;
        // the snooped cache gets one full cycle before its answer counts
        if (held_q) begin
          if (ccwrite[oth] && dWEN[oth]) begin
            state_d = C2C;
          end else if (dREN[req_q]) begin
            state_d = DRAM_RD;
          end else begin
            dwait[req_q] = 1'b0;
            done         = 1'b1;
          end
        end
      end
      C2C: begin
        ccwait[oth] = 1'b1;
        ccsnoopaddr = wput(addr_q, oth);
        dload       = wput(wsel(dstore, oth), req_q);
        ramWEN      = 1'b1;
        ramaddr     = wsel(daddr, oth);
        ramstore    = wsel(dstore, oth);
        if (acc) begin
          dwait = '0;
          done  = 1'b1;
        end
      end
      DRAM_RD: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (acc) begin
          dwait[req_q] = 1'b0;
          dload        = wput(ramload, req_q);
          done         = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      rr_d    = oth;
    end
  end

  // controller state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      req_q   <= 1'b0;
      held_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      held_q  <= held_d;
      addr_q  <= addr_d;
    end
  end

`ifdef BUS_PERF_CNT_EN
  logic [31:0] c2c_q, c2c_d;
  logic [31:0] racc_q, racc_d;
  logic        c2c_hit, ram_hit;

  assign c2c_hit = (state_q == C2C) && acc;
  assign ram_hit = acc && (ramREN || ramWEN);

  // saturating event counters
  always_comb begin
    c2c_d  = c2c_q;
    racc_d = racc_q;
    if (c2c_hit && (c2c_q != '1))
      c2c_d = c2c_q + 32'd1;
    if (ram_hit && (racc_q != '1))
      racc_d = racc_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c2c_q  <= '0;
      racc_q <= '0;
    end else begin
      c2c_q  <= c2c_d;
      racc_q <= racc_d;
    end
  end

  assign c2c_count        = c2c_q;
  assign ram_access_count = racc_q;
`endif

endmodule
